fifo_ctrl: RTL



---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_ptr.sv | 31 +++
 rtl/fifo_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared operation and status encodings for the FIFO controller.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Operation code is formed as {write_accepted, read_accepted}
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_RW  = 2'b11;

    // Status is encoded directly as the {full, empty} flag pair
    typedef enum logic [1:0] {
        ST_PART  = 2'b00,
        ST_EMPTY = 2'b01,
        ST_FULL  = 2'b10
    } fifo_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr
// Purpose  : W-bit wrapping pointer with increment enable and look-ahead next.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic [W-1:0] next
);

    logic [W-1:0] r_ptr;

    assign next = r_ptr + W'(1);
    assign ptr  = r_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Purpose  : Pointer, occupancy and status controller for a FWFT FIFO.
//            Optional macro FIFO_CTRL_ERR_EN adds sticky overflow/underflow.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int W        = 2,
    parameter int AF_LEVEL = (1 << W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
`ifdef FIFO_CTRL_ERR_EN
    input  logic         err_clr,
    output logic         overflow,
    output logic         underflow,
`endif
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         full,
    output logic         empty,
    output logic         almost_full,
    output logic         almost_empty,
    output logic [W:0]   count
);

    localparam logic [W:0] c_af_level = (W+1)'(AF_LEVEL);
    localparam logic [W:0] c_ae_level = (W+1)'(AE_LEVEL);
    localparam logic       c_af_rst   = (AF_LEVEL <= 0);
    localparam logic       c_ae_rst   = (AE_LEVEL >= 0);

    fifo_state_t  r_state;
    fifo_state_t  w_state_nxt;
    logic [W:0]   r_count;
    logic [W:0]   w_count_nxt;
    logic         r_almost_full;
    logic         r_almost_empty;
    logic         w_wa;
    logic         w_ra;
    logic [1:0]   w_op;
    logic [W-1:0] w_wptr_next;
    logic [W-1:0] w_rptr_next;

    assign full  = r_state[1];
    assign empty = r_state[0];

    assign w_wa  = wr & ~full;
    assign w_ra  = rd & ~empty;
    assign w_op  = {w_wa, w_ra};
    assign wr_en = w_wa;

    fifo_ptr #(.W(W)) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wa),
        .ptr   (w_addr),
        .next  (w_wptr_next)
    );

    fifo_ptr #(.W(W)) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_ra),
        .ptr   (r_addr),
        .next  (w_rptr_next)
    );

    always_comb begin
        w_count_nxt = r_count;
        w_state_nxt = r_state;
        case (w_op)
            OP_WR: begin
                w_count_nxt = r_count + (W+1)'(1);
                // Pointers meeting after a write means the ring is exhausted
                w_state_nxt = (w_wptr_next == r_addr) ? ST_FULL : ST_PART;
            end
            OP_RD: begin
                w_count_nxt = r_count - (W+1)'(1);
                w_state_nxt = (w_rptr_next == w_addr) ? ST_EMPTY : ST_PART;
            end
            default: begin
                w_count_nxt = r_count;
                w_state_nxt = r_state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_EMPTY;
            r_count        <= '0;
            r_almost_full  <= c_af_rst;
            r_almost_empty <= c_ae_rst;
        end else begin
            r_state        <= w_state_nxt;
            r_count        <= w_count_nxt;
            r_almost_full  <= (w_count_nxt >= c_af_level);
            r_almost_empty <= (w_count_nxt <= c_ae_level);
        end
    end

    assign count        = r_count;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

`ifdef FIFO_CTRL_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error event on the same edge as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr & full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (rd & empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire
